// File: rtl/vx_fetch_sched.sv
// Per-warp fetch scheduler: round-robin pick of one eligible warp into a single held request register.
// Define FETCH_SCHED_CREDIT_EN to add per-warp ibuffer credit counters that gate eligibility.
module vx_fetch_sched #(
  parameter int                 NUM_WARPS   = 4,
  parameter int                 NUM_THREADS = 4,
  parameter int                 PC_BITS     = 31,
  parameter int                 UUID_WIDTH  = 16,
  parameter int                 IBUF_SIZE   = 4,
  parameter logic [PC_BITS-1:0] STARTUP_PC  = PC_BITS'('h4000_0000),
  parameter int                 NW_WIDTH    = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_WARPS-1:0]   warp_active,
  input  logic [NUM_WARPS-1:0]   warp_stall,
  input  logic                   pc_load_valid,
  input  logic [NW_WIDTH-1:0]    pc_load_wid,
  input  logic [PC_BITS-1:0]     pc_load_PC,
  input  logic [NUM_THREADS-1:0] pc_load_tmask,
  input  logic [NUM_WARPS-1:0]   ibuf_pop,
  output logic                   sched_valid,
  input  logic                   sched_ready,
  output logic [NW_WIDTH-1:0]    sched_wid,
  output logic [PC_BITS-1:0]     sched_PC,
  output logic [NUM_THREADS-1:0] sched_tmask,
  output logic [UUID_WIDTH-1:0]  sched_uuid,
  output logic                   busy
);

  logic [PC_BITS-1:0]     pc_tbl    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_tbl [NUM_WARPS];
  logic [NW_WIDTH-1:0]    rr_ptr;
  logic [UUID_WIDTH-1:0]  uuid_cnt;
  logic [NUM_WARPS-1:0]   credit_ok;
  logic [NUM_WARPS-1:0]   eligible;
  logic [NW_WIDTH-1:0]    winner;
  logic [NW_WIDTH-1:0]    idx;
  logic                   found;
  logic                   fire;
  logic                   load;
  logic                   flush;

  assign fire  = sched_valid & sched_ready;
  // A redirect to the warp whose request is stuck in the output register kills that request.
  assign flush = sched_valid & ~sched_ready & pc_load_valid & (pc_load_wid == sched_wid);
  assign load  = found & (~sched_valid | fire);

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = warp_active[w] & ~warp_stall[w] & credit_ok[w]
                  & ~(sched_valid & (sched_wid == NW_WIDTH'(w)));
    end
  end

  // Search order rr_ptr+1 .. rr_ptr (wrapping); walking it backwards lets the nearest hit win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_WARPS; i >= 1; i--) begin
      idx = rr_ptr + NW_WIDTH'(i);
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // NOTE: the PC/tmask table is a small register array with a defined startup value, so it is reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_tbl[w]    <= STARTUP_PC;
        tmask_tbl[w] <= '1;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (pc_load_valid && pc_load_wid == NW_WIDTH'(w)) begin
          pc_tbl[w]    <= pc_load_PC;
          tmask_tbl[w] <= pc_load_tmask;
        end else if (fire && sched_wid == NW_WIDTH'(w)) begin
          pc_tbl[w] <= sched_PC + PC_BITS'(2);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched_valid <= 1'b0;
      sched_wid   <= '0;
      sched_PC    <= STARTUP_PC;
      sched_tmask <= '1;
      sched_uuid  <= '0;
      uuid_cnt    <= '0;
      rr_ptr      <= NW_WIDTH'(NUM_WARPS - 1);
    end else if (load) begin
      sched_valid <= 1'b1;
      sched_wid   <= winner;
      sched_PC    <= pc_tbl[winner];
      sched_tmask <= tmask_tbl[winner];
      sched_uuid  <= uuid_cnt;
      uuid_cnt    <= uuid_cnt + UUID_WIDTH'(1);
      rr_ptr      <= winner;
    end else if (fire || flush) begin
      sched_valid <= 1'b0;
    end
  end

`ifdef FETCH_SCHED_CREDIT_EN
  localparam int CW = $clog2(IBUF_SIZE + 1);

  logic [CW-1:0]        credit     [NUM_WARPS];
  logic [CW-1:0]        credit_nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] credit_nz;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      credit_ok[w]  = credit[w] < CW'(IBUF_SIZE);
      credit_nz[w]  = credit[w] != '0;
      credit_nxt[w] = credit[w];
      if (load && winner == NW_WIDTH'(w))
        credit_nxt[w] = credit_nxt[w] + CW'(1);
      if (flush && sched_wid == NW_WIDTH'(w))
        credit_nxt[w] = credit_nxt[w] - CW'(1);
      // A pop against an empty counter is ignored rather than wrapping.
      if (ibuf_pop[w] && credit[w] != '0 && credit_nxt[w] != '0)
        credit_nxt[w] = credit_nxt[w] - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) credit[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) credit[w] <= credit_nxt[w];
    end
  end

  assign busy = sched_valid | (|credit_nz);

`ifndef SYNTHESIS
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_pop_chk
    pop_at_zero: assert property (@(posedge clk) disable iff (!reset)
      !(ibuf_pop[w] && credit[w] == '0));
  end
`endif
`else
  logic unused_pop;
  assign unused_pop = ^ibuf_pop;
  assign credit_ok  = '1;
  assign busy       = sched_valid;
`endif

endmodule
